// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the
// UART transmitter write port.
//   req_valid/req_data/req_last : per-requester byte offer (requester i at req_data[i])
//   req_ready                   : per-requester byte accept
//   tx_ready                    : transmitter can take a byte
//   tx_data_reg_wr/tx_data      : one-cycle write strobe and byte to the transmitter
// slave  = arbiter side, master = requester/transmitter side (testbench).
interface uart_tx_arb_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0][7:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_ready;
  logic                 tx_data_reg_wr;
  logic [7:0]           tx_data;

  modport slave  (input  req_valid, req_data, req_last, tx_ready,
                  output req_ready, tx_data_reg_wr, tx_data);
  modport master (output req_valid, req_data, req_last, tx_ready,
                  input  req_ready, tx_data_reg_wr, tx_data);
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte streams.
// A grant is held until the requester's last byte (or a lock timeout), so
// packets never interleave. Each accepted byte is written to the transmitter
// with a one-cycle strobe, then HOLD_CYC cycles pass before tx_ready is
// looked at again.
// Ports:
//   ACLK, ARESETn : clock, async active-low reset
//   enable        : permits new grants (a packet in flight always completes)
//   bus           : requester + transmitter handshake (uart_tx_arb_if.slave)
//   grant_id      : current / most recent granted requester
//   busy          : high whenever not idle
//   tmo_evt       : one-cycle pulse when a stalled lock is revoked
module uart_tx_arb #(
  parameter int NREQ     = 4,
  parameter int HOLD_CYC = 2,
  parameter int LOCK_TMO = 255
) (
  input  logic               ACLK,
  input  logic               ARESETn,
  input  logic               enable,
  uart_tx_arb_if.slave       bus,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic               tmo_evt
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {IDLE, SEND, HOLD} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [7:0]    tmo_q, tmo_d;
  logic [3:0]    hold_q, hold_d;
  logic          last_q, last_d;
  logic [7:0]    data_q, data_d;
  logic          wr_q, wr_d;

  logic [IW-1:0] pick;
  logic          pick_vld;
  logic [SW-1:0] slot;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] g);
    return (int'(g) == NREQ - 1) ? '0 : g + IW'(1);
  endfunction

  // Scan from the highest offset down so the lowest offset past rr_q wins.
  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_q;
    slot     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = SW'(rr_q) + SW'(k);
      if (slot >= SW'(NREQ)) slot = slot - SW'(NREQ);
      if (bus.req_valid[slot[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick     = slot[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    rr_d          = rr_q;
    tmo_d         = tmo_q;
    hold_d        = hold_q;
    last_d        = last_q;
    data_d        = data_q;
    wr_d          = 1'b0;
    tmo_evt       = 1'b0;
    bus.req_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (enable && pick_vld) begin
          grant_d = pick;
          tmo_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        bus.req_ready[grant_q] = bus.tx_ready;
        // A transfer beats the timeout so an offered-and-accepted byte is
        // never dropped on the revoke cycle.
        if (bus.tx_ready && bus.req_valid[grant_q]) begin
          data_d  = bus.req_data[grant_q];
          last_d  = bus.req_last[grant_q];
          tmo_d   = '0;
          hold_d  = 4'(HOLD_CYC - 1);
          wr_d    = 1'b1;
          state_d = HOLD;
        end else if (tmo_q == 8'(LOCK_TMO)) begin
          tmo_evt = 1'b1;
          rr_d    = nxt(grant_q);
          state_d = IDLE;
        end else if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      HOLD: begin
        if (hold_q == 4'd0) begin
          if (last_q) begin
            rr_d    = nxt(grant_q);
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
      hold_q  <= '0;
      last_q  <= 1'b0;
      data_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
    end
  end

  // Strobe is a flop, so it lands in the first HOLD cycle and is cleared
  // directly by reset.
  assign bus.tx_data_reg_wr = wr_q;
  assign bus.tx_data        = data_q;
  assign grant_id           = 3'(grant_q);
  assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arb.sv
module tb_uart_tx_arb;
  localparam int NREQ = 4;
  localparam int HOLD = 2;
  localparam int TMO  = 8;

  logic       ACLK = 1'b0;
  logic       ARESETn = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] grant_id;
  logic       busy, tmo_evt;

  uart_tx_arb_if #(.NREQ(NREQ)) bus();

  uart_tx_arb #(.NREQ(NREQ), .HOLD_CYC(HOLD), .LOCK_TMO(TMO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable), .bus(bus),
    .grant_id(grant_id), .busy(busy), .tmo_evt(tmo_evt));

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Requester packet buffers (9 bits: last flag + byte)
  logic [8:0]      pbuf [NREQ][64];
  int              head [NREQ];
  int              tail [NREQ];
  logic [NREQ-1:0] took;
  int              vpct = 100, rdy_pct = 100;

  // Logs filled by the compare process
  logic [7:0] wlog [256];
  int         wcyc [256];
  int         nw = 0, ntmo = 0, tmo_cyc = 0;
  int         acc_cyc [NREQ];

  // Reference model: who owns the transmitter, from which cycle bytes may be
  // taken, when the lock ends, and when the next write strobe is due.
  int         m_own, m_rr, m_gid, m_next, m_rel, m_wr_at, m_stall;
  logic [7:0] m_txd;

  task automatic m_clear();
    m_own = -1; m_rr = 0; m_gid = 0; m_next = 0; m_rel = -1;
    m_wr_at = -1; m_stall = 0; m_txd = 8'h00;
  endtask

  task automatic model_step();
    bit sending, xfer, tmo;
    logic [NREQ-1:0] er;
    int g;
    if (m_rel == cyc) begin m_own = -1; m_rel = -1; end
    sending = (m_own >= 0) && (cyc >= m_next);
    er = '0; xfer = 1'b0;
    if (sending && bus.tx_ready) begin
      er[m_own] = 1'b1;
      xfer = bus.req_valid[m_own];
    end
    tmo = sending && !xfer && (m_stall == TMO);
    chk("req_ready", bus.req_ready, er);
    chk("tx_wr", bus.tx_data_reg_wr, cyc == m_wr_at);
    chk("tx_data", bus.tx_data, m_txd);
    chk("grant_id", grant_id, m_gid);
    chk("busy", busy, m_own >= 0);
    chk("tmo_evt", tmo_evt, tmo);
    if (bus.tx_data_reg_wr === 1'b1 && nw < 256) begin
      wlog[nw] = bus.tx_data; wcyc[nw] = cyc; nw++;
    end
    if (tmo_evt === 1'b1) begin ntmo++; tmo_cyc = cyc; end
    took = '0;
    if (m_own < 0) begin
      g = -1;
      if (enable)
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && bus.req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      if (g >= 0) begin
        m_own = g; m_gid = g; m_stall = 0; m_next = cyc + 1; m_rel = -1;
      end
    end else if (xfer) begin
      took[m_own] = 1'b1;
      acc_cyc[m_own] = cyc;
      m_txd   = bus.req_data[m_own];
      m_wr_at = cyc + 1;
      m_stall = 0;
      m_next  = cyc + 1 + HOLD;
      if (bus.req_last[m_own]) begin
        m_rel = cyc + 1 + HOLD;
        m_rr  = (m_own + 1) % NREQ;
      end
    end else if (tmo) begin
      m_rel = cyc + 1;
      m_rr  = (m_own + 1) % NREQ;
    end else if (sending && m_stall < 255) begin
      m_stall++;
    end
  endtask

  // Single compare process
  always @(negedge ACLK) begin
    if (!ARESETn) begin
      m_clear();
      took = '0;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_tx_wr", bus.tx_data_reg_wr, 0);
      chk("rst_tx_data", bus.tx_data, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tmo_evt", tmo_evt, 0);
    end else begin
      model_step();
    end
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      if (took[i]) begin
        took[i] = 1'b0;
        if (head[i] != tail[i]) head[i]++;
      end
      if (head[i] != tail[i]) begin
        bus.req_valid[i] = ($urandom_range(99) < vpct);
        {bus.req_last[i], bus.req_data[i]} = pbuf[i][head[i] % 64];
      end else begin
        bus.req_valid[i] = 1'b0;
        bus.req_last[i]  = 1'b0;
        bus.req_data[i]  = 8'h00;
      end
    end
    bus.tx_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic tick();
    @(posedge ACLK); #1; drive();
  endtask

  task automatic push(input int r, input int n, input logic [7:0] base, input bit lst);
    for (int k = 0; k < n; k++) begin
      pbuf[r][tail[r] % 64] = {(lst && k == n - 1), 8'(base + k)};
      tail[r]++;
    end
  endtask

  function automatic bit qempty();
    for (int i = 0; i < NREQ; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_q();
    for (int i = 0; i < NREQ; i++) begin head[i] = 0; tail[i] = 0; end
    took = '0;
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while ((busy || !qempty()) && k < maxc) begin tick(); k++; end
    chk("drain_bound", busy || !qempty(), 0);
  endtask

  task automatic do_reset();
    ARESETn = 1'b0;
    clear_q();
    drive();
    #1;
    chk("lit_rst_busy", busy, 0);
    chk("lit_rst_tx_data", bus.tx_data, 0);
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
    drive();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_q();
    drive();
    do_reset();
    enable = 1'b1;

    // Single byte from requester 1, then rr_ptr must point at 2
    tick();
    push(1, 1, 8'h41, 1'b1); drive();            // cycle N
    tick(); chk("t1_ready_n1", bus.req_ready, 4'b0010);
    tick(); chk("t1_wr_n2", bus.tx_data_reg_wr, 1);
            chk("t1_data_n2", bus.tx_data, 8'h41);
    tick(); chk("t1_busy_n3", busy, 1);
    tick(); chk("t1_busy_n4", busy, 0);
    push(0, 1, 8'h50, 1'b1); push(2, 1, 8'h52, 1'b1); drive();
    tick(); chk("t1_rr_grant", grant_id, 2);
            chk("t1_rr_ready", bus.req_ready, 4'b0100);
    wait_drain(100);

    // Round robin: 0, 2, 3, then 0 again
    do_reset();
    nw = 0;
    push(0, 1, 8'hA0, 1'b1); push(0, 1, 8'hB0, 1'b1);
    push(2, 1, 8'hA2, 1'b1); push(3, 1, 8'hA3, 1'b1);
    drive();
    wait_drain(100);
    chk("t2_count", nw, 4);
    chk("t2_b0", wlog[0], 8'hA0); chk("t2_b1", wlog[1], 8'hA2);
    chk("t2_b2", wlog[2], 8'hA3); chk("t2_b3", wlog[3], 8'hB0);

    // Packet lock: req1's 3 bytes go out back to back before req0
    do_reset();
    nw = 0;
    push(1, 3, 8'h10, 1'b1); drive();
    tick();
    push(0, 1, 8'h20, 1'b1); drive();
    wait_drain(100);
    chk("t3_count", nw, 4);
    chk("t3_b0", wlog[0], 8'h10); chk("t3_b1", wlog[1], 8'h11);
    chk("t3_b2", wlog[2], 8'h12); chk("t3_b3", wlog[3], 8'h20);
    chk("t3_gap01", wcyc[1] - wcyc[0], HOLD + 1);
    chk("t3_gap12", wcyc[2] - wcyc[1], HOLD + 1);

    // Backpressure for 20 cycles. With an 8-cycle lock timeout the lone
    // requester is revoked at S+8 and S+18 and re-granted, so S+20 is SEND.
    nw = 0; ntmo = 0; rdy_pct = 0;
    push(3, 1, 8'h55, 1'b1); drive();
    tick();                                      // S
    repeat (20) begin tick(); chk("t4_no_ready", bus.req_ready, 0); end
    chk("t4_no_wr", nw, 0);
    chk("t4_tmo_count", ntmo, 2);
    rdy_pct = 100; bus.tx_ready = 1'b1; #1;
    chk("t4_accept", bus.req_ready, 4'b1000);
    tick(); chk("t4_wr", bus.tx_data_reg_wr, 1);
            chk("t4_data", bus.tx_data, 8'h55);
    wait_drain(100);

    // Timeout: req2 sends a non-last byte then stops; req3 is pending
    do_reset();
    nw = 0; ntmo = 0;
    push(2, 1, 8'h30, 1'b0); push(3, 1, 8'h33, 1'b1); drive();
    wait_drain(200);
    chk("t5_tmo_count", ntmo, 1);
    chk("t5_tmo_lat", tmo_cyc - acc_cyc[2], HOLD + 1 + TMO);
    chk("t5_count", nw, 2);
    chk("t5_b1", wlog[1], 8'h33);
    chk("t5_gid", grant_id, 3);

    // Enable low holds off grants
    enable = 1'b0;
    push(0, 1, 8'h70, 1'b1); push(1, 1, 8'h71, 1'b1); drive();
    repeat (5) begin tick(); chk("t6_busy_off", busy, 0); end
    enable = 1'b1;
    tick(); chk("t6_busy_on", busy, 1);
    wait_drain(100);

    // Reset during HOLD of a 2-byte packet
    begin
      int k = 0;
      push(1, 2, 8'h61, 1'b1); drive();
      while (bus.tx_data_reg_wr !== 1'b1 && k < 20) begin tick(); k++; end
      chk("t7_wr_seen", bus.tx_data_reg_wr, 1);
      #2;
      ARESETn = 1'b0;
      clear_q(); drive();
      #1;
      chk("t7_wr", bus.tx_data_reg_wr, 0);
      chk("t7_data", bus.tx_data, 0);
      chk("t7_busy", busy, 0);
      chk("t7_gid", grant_id, 0);
      chk("t7_ready", bus.req_ready, 0);
      nw = 0;
      repeat (2) @(posedge ACLK);
      #1; ARESETn = 1'b1; drive();
      repeat (10) tick();
      chk("t7_no_wr", nw, 0);
    end

    // Randomized traffic with periodic stall windows that provoke timeouts
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      vpct    = (i % 500 < 100) ? 20 : 75;
      rdy_pct = 70;
      enable  = ($urandom_range(99) < 95);
      if ($urandom_range(7) == 0) begin
        int r;
        r = $urandom_range(NREQ - 1);
        if (tail[r] - head[r] < 40)
          push(r, 1 + $urandom_range(3), 8'($urandom_range(255)), 1'b1);
      end
      tick();
    end
    vpct = 100; rdy_pct = 100; enable = 1'b1;
    wait_drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
